// File: rtl/alu_seq_pkg.sv
// Shared encodings and the DECODE transition for the SRM ALU sequencer.
// 101/01 is handled as CMP only when the caller passes cmp_en (set from ALU_SEQ_CMP_EN).
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RM    = 3'b001;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RN    = 3'b100;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOT    = 2'b11;

    // S_WAIT as the result means the instruction is unsupported.
    function automatic state_t decode_next(input logic [2:0] opc,
                                           input logic [1:0] op,
                                           input logic       cmp_en);
        state_t nxt;
        nxt = S_WAIT;
        if (opc == OPC_MOV) begin
            if (op == 2'b10)      nxt = S_WRITE_IMM;
            else if (op == 2'b00) nxt = S_GET_B;
        end else if (opc == OPC_ALU) begin
            case (op)
                ALU_ADD: nxt = S_GET_A;
                ALU_SUB: nxt = cmp_en ? S_GET_A : S_WAIT;
                ALU_AND: nxt = S_GET_A;
                ALU_NOT: nxt = S_GET_B;
                default: nxt = S_WAIT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the SRM register file / A-B-C / ALU datapath.
// ALU_SEQ_CMP_EN: when defined, 101/01 runs as CMP (status load, no writeback); otherwise illegal.
module alu_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned NSEL_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    output logic              w,
    output logic [NSEL_W-1:0] nsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic              write,
    output logic [1:0]        alu_op,
    output logic              illegal
);
    import alu_seq_pkg::*;

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec
        $error("alu_sequencer: EXEC_CYCLES must be in 1..15");
    end
    if (NSEL_W != 3) begin : g_bad_nsel
        $error("alu_sequencer: NSEL_W must be 3");
    end

`ifdef ALU_SEQ_CMP_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        opc_q, opc_d;
    logic [1:0]        op_q, op_d;

    logic              w_q, w_d;
    logic [NSEL_W-1:0] nsel_q, nsel_d;
    logic              loada_q, loada_d;
    logic              loadb_q, loadb_d;
    logic              loadc_q, loadc_d;
    logic              loads_q, loads_d;
    logic              asel_q, asel_d;
    logic              bsel_q, bsel_d;
    logic [1:0]        vsel_q, vsel_d;
    logic              write_q, write_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              illegal_q, illegal_d;

    logic              is_cmp_q;
    logic              is_mov_d, is_cmp_d, is_mvn_d, last_d;

    assign is_cmp_q = (opc_q == OPC_ALU) && (op_q == ALU_SUB);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opc_d     = opc_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                    opc_d   = opcode;
                    op_d    = op;
                end
            end
            S_DECODE: begin
                state_d   = decode_next(opc_q, op_q, CMP_EN);
                illegal_d = (state_d == S_WAIT);
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: begin
                state_d = S_EXEC;
                cnt_d   = '0;
            end
            S_EXEC: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = is_cmp_q ? S_WAIT : S_WRITE_REG;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WRITE_REG, S_WRITE_IMM: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // Outputs are registered: decode them from the state about to be entered.
    assign is_mov_d = (opc_d == OPC_MOV);
    assign is_cmp_d = (opc_d == OPC_ALU) && (op_d == ALU_SUB);
    assign is_mvn_d = (opc_d == OPC_ALU) && (op_d == ALU_NOT);
    assign last_d   = (cnt_d == LAST);

    always_comb begin
        w_d      = 1'b0;
        nsel_d   = NSEL_NONE;
        loada_d  = 1'b0;
        loadb_d  = 1'b0;
        loadc_d  = 1'b0;
        loads_d  = 1'b0;
        asel_d   = 1'b0;
        bsel_d   = 1'b0;
        vsel_d   = VSEL_C;
        write_d  = 1'b0;
        alu_op_d = ALU_ADD;
        case (state_d)
            S_WAIT: w_d = 1'b1;
            S_GET_A: begin
                nsel_d  = NSEL_RN;
                loada_d = 1'b1;
            end
            S_GET_B: begin
                nsel_d  = NSEL_RM;
                loadb_d = 1'b1;
            end
            S_EXEC: begin
                asel_d   = is_mov_d || is_mvn_d;
                alu_op_d = is_mov_d ? ALU_ADD : op_d;
                loadc_d  = last_d;
                loads_d  = last_d && is_cmp_d;
            end
            S_WRITE_REG: begin
                nsel_d  = NSEL_RD;
                vsel_d  = VSEL_C;
                write_d = 1'b1;
            end
            S_WRITE_IMM: begin
                nsel_d  = NSEL_RN;
                vsel_d  = VSEL_IMM8;
                write_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            opc_q     <= '0;
            op_q      <= '0;
            w_q       <= 1'b1;
            nsel_q    <= '0;
            loada_q   <= 1'b0;
            loadb_q   <= 1'b0;
            loadc_q   <= 1'b0;
            loads_q   <= 1'b0;
            asel_q    <= 1'b0;
            bsel_q    <= 1'b0;
            vsel_q    <= '0;
            write_q   <= 1'b0;
            alu_op_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opc_q     <= opc_d;
            op_q      <= op_d;
            w_q       <= w_d;
            nsel_q    <= nsel_d;
            loada_q   <= loada_d;
            loadb_q   <= loadb_d;
            loadc_q   <= loadc_d;
            loads_q   <= loads_d;
            asel_q    <= asel_d;
            bsel_q    <= bsel_d;
            vsel_q    <= vsel_d;
            write_q   <= write_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
        end
    end

    assign w       = w_q;
    assign nsel    = nsel_q;
    assign loada   = loada_q;
    assign loadb   = loadb_q;
    assign loadc   = loadc_q;
    assign loads   = loads_q;
    assign asel    = asel_q;
    assign bsel    = bsel_q;
    assign vsel    = vsel_q;
    assign write   = write_q;
    assign alu_op  = alu_op_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with EXEC_CYCLES=3; outputs are packed into one word per cycle.
// CMP expectations follow ALU_SEQ_CMP_EN as defined for the build.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, loada, loadb, loadc, loads, asel, bsel, write, illegal;
    logic [2:0] nsel;
    logic [1:0] vsel, alu_op;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, illegal}
    logic [15:0] obs;
    assign obs = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, illegal};

    localparam logic [15:0] V_WAIT  = 16'h8000;
    localparam logic [15:0] V_ILL   = 16'h8001;
    localparam logic [15:0] V_DEC   = 16'h0000;
    localparam logic [15:0] V_GETA  = 16'h4800;
    localparam logic [15:0] V_GETB  = 16'h1400;
    localparam logic [15:0] V_WREG  = 16'h2008;
    localparam logic [15:0] V_WIMM  = 16'h4028;
    localparam logic [15:0] V_EADD  = 16'h0000;
    localparam logic [15:0] V_LADD  = 16'h0200;
    localparam logic [15:0] V_ECMP  = 16'h0002;
    localparam logic [15:0] V_LCMP  = 16'h0302;
    localparam logic [15:0] V_EAND  = 16'h0004;
    localparam logic [15:0] V_LAND  = 16'h0204;
    localparam logic [15:0] V_EMVN  = 16'h0086;
    localparam logic [15:0] V_EMOV  = 16'h0080;
    localparam logic [15:0] V_LMOV  = 16'h0280;

    alu_sequencer #(.EXEC_CYCLES(3), .NSEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
        .alu_op(alu_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] opc, input logic [1:0] o);
        s = 1'b1; opcode = opc; op = o;
        tick();
        s = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s = 1'b1; opcode = 3'b110; op = 2'b10;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs !== V_WAIT) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %h expected %h", i, obs, V_WAIT);
            end
        end
        rst_n = 1'b1; s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs !== V_WAIT) begin
                n_bad++;
                $display("FAIL idle cyc %0d: got %h expected %h", i, obs, V_WAIT);
            end
        end
    endtask

    task automatic test_mov_imm();
        logic [15:0] exp [0:3];
        exp = '{V_DEC, V_WIMM, V_WAIT, V_WAIT};
        start(3'b110, 2'b10);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL mov_imm cyc %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_add();
        logic [15:0] exp [0:7];
        exp = '{V_DEC, V_GETA, V_GETB, V_EADD, V_EADD, V_LADD, V_WREG, V_WAIT};
        start(3'b101, 2'b00);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL add cyc %0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i < 7) tick();
        end
        tick();
    endtask

    task automatic test_and_movreg();
        logic [15:0] ea [0:7];
        logic [15:0] em [0:6];
        ea = '{V_DEC, V_GETA, V_GETB, V_EAND, V_EAND, V_LAND, V_WREG, V_WAIT};
        em = '{V_DEC, V_GETB, V_EMOV, V_EMOV, V_LMOV, V_WREG, V_WAIT};
        start(3'b101, 2'b10);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs !== ea[i]) begin
                n_bad++;
                $display("FAIL and cyc %0d: got %h expected %h", i, obs, ea[i]);
            end
            if (i < 7) tick();
        end
        start(3'b110, 2'b00);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (obs !== em[i]) begin
                n_bad++;
                $display("FAIL mov_reg cyc %0d: got %h expected %h", i, obs, em[i]);
            end
            if (i < 6) tick();
        end
        tick();
    endtask

    task automatic test_cmp();
`ifdef ALU_SEQ_CMP_EN
        logic [15:0] exp [0:7];
        exp = '{V_DEC, V_GETA, V_GETB, V_ECMP, V_ECMP, V_LCMP, V_WAIT, V_WAIT};
        start(3'b101, 2'b01);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL cmp cyc %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
`else
        logic [15:0] exp [0:3];
        exp = '{V_DEC, V_ILL, V_WAIT, V_WAIT};
        start(3'b101, 2'b01);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL cmp_off cyc %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
`endif
    endtask

    task automatic test_illegal_and_ignore();
        logic [15:0] ei [0:2];
        logic [15:0] ea [0:7];
        ei = '{V_DEC, V_ILL, V_WAIT};
        ea = '{V_DEC, V_GETA, V_GETB, V_EADD, V_EADD, V_LADD, V_WREG, V_WAIT};
        start(3'b111, 2'b00);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== ei[i]) begin
                n_bad++;
                $display("FAIL illegal cyc %0d: got %h expected %h", i, obs, ei[i]);
            end
            if (i < 2) tick();
        end
        tick();
        start(3'b101, 2'b00);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs !== ea[i]) begin
                n_bad++;
                $display("FAIL add_ignore cyc %0d: got %h expected %h", i, obs, ea[i]);
            end
            s = (i < 6);
            opcode = 3'b110; op = 2'b10;
            if (i < 7) tick();
        end
        s = 1'b0;
        tick();
        n_cmp++;
        if (obs !== V_WAIT) begin
            n_bad++;
            $display("FAIL add_ignore_idle: got %h expected %h", obs, V_WAIT);
        end
    endtask

    task automatic test_reset_mid_mvn();
        logic [15:0] exp [0:2];
        exp = '{V_DEC, V_GETB, V_EMVN};
        start(3'b101, 2'b11);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== exp[i]) begin
                n_bad++;
                $display("FAIL mvn cyc %0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i < 2) tick();
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (obs !== V_WAIT) begin
            n_bad++;
            $display("FAIL mvn_reset: got %h expected %h", obs, V_WAIT);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (obs !== V_WAIT) begin
                n_bad++;
                $display("FAIL mvn_after_reset cyc %0d: got %h expected %h", i, obs, V_WAIT);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; s = 1'b0; opcode = '0; op = '0;
        test_reset();
        test_mov_imm();
        test_add();
        test_and_movreg();
        test_cmp();
        test_illegal_and_ignore();
        test_reset_mid_mvn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
